// File: rtl/risc32_mem_arbiter_if.sv
// Bus bundle for the shared instruction/data RAM arbiter:
// fetch port, data port and the single-port RAM port.
interface risc32_mem_arbiter_if #(
  parameter int RAM_AW = 14
) ();

  logic              if_ce_i;
  logic [31:0]       if_addr_i;
  logic [31:0]       if_data_o;
  logic              if_ready_o;

  logic              d_ce_i;
  logic              d_we_i;
  logic [3:0]        d_sel_i;
  logic [31:0]       d_addr_i;
  logic [31:0]       d_wdata_i;
  logic [31:0]       d_rdata_o;
  logic              d_ready_o;

  logic              ram_ce_o;
  logic              ram_we_o;
  logic [3:0]        ram_sel_o;
  logic [RAM_AW-1:0] ram_addr_o;
  logic [31:0]       ram_wdata_o;
  logic [31:0]       ram_rdata_i;

  logic              stall_req_o;

  modport slave (
    input  if_ce_i,
    input  if_addr_i,
    output if_data_o,
    output if_ready_o,
    input  d_ce_i,
    input  d_we_i,
    input  d_sel_i,
    input  d_addr_i,
    input  d_wdata_i,
    output d_rdata_o,
    output d_ready_o,
    output ram_ce_o,
    output ram_we_o,
    output ram_sel_o,
    output ram_addr_o,
    output ram_wdata_o,
    input  ram_rdata_i,
    output stall_req_o
  );

  modport master (
    output if_ce_i,
    output if_addr_i,
    input  if_data_o,
    input  if_ready_o,
    output d_ce_i,
    output d_we_i,
    output d_sel_i,
    output d_addr_i,
    output d_wdata_i,
    input  d_rdata_o,
    input  d_ready_o,
    input  ram_ce_o,
    input  ram_we_o,
    input  ram_sel_o,
    input  ram_addr_o,
    input  ram_wdata_o,
    output ram_rdata_i,
    input  stall_req_o
  );

endinterface

// File: rtl/risc32_mem_arbiter.sv
// Fetch/data arbiter for one single-port synchronous RAM.
// Data has priority; a burst counter forces a waiting fetch in.
module risc32_mem_arbiter #(
  parameter int          RAM_AW         = 14,
  parameter logic [31:0] IO_BASE        = 32'h0000_F000,
  parameter int          DATA_BURST_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  risc32_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    READ_CAP,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } owner_t;

  state_t            state;
  owner_t            owner;
  logic [3:0]        burst_cnt;
  logic              we_q;

  logic              ram_ce_q;
  logic              ram_we_q;
  logic [3:0]        ram_sel_q;
  logic [RAM_AW-1:0] ram_addr_q;
  logic [31:0]       ram_wdata_q;

  logic [31:0]       if_data_q;
  logic              if_ready_q;
  logic [31:0]       d_rdata_q;
  logic              d_ready_q;

  logic              burst_full;
  logic              d_win;
  logic              f_win;
  logic              d_io;
  logic              unused_addr;

  assign burst_full = (burst_cnt == 4'(DATA_BURST_MAX));
  assign d_win      = bus.d_ce_i & ~(bus.if_ce_i & burst_full);
  assign f_win      = ~d_win & bus.if_ce_i;
  assign d_io       = (bus.d_addr_i >= IO_BASE);

  assign unused_addr = ^{bus.if_addr_i[31:RAM_AW+2],
                         bus.if_addr_i[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= OWN_NONE;
      burst_cnt   <= '0;
      we_q        <= 1'b0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_sel_q   <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_data_q   <= '0;
      if_ready_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_ready_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // burst_cnt only counts data grants that made a fetch wait
          if (!bus.if_ce_i)
            burst_cnt <= '0;
          else if (d_win && !burst_full)
            burst_cnt <= burst_cnt + 4'd1;
          else if (f_win)
            burst_cnt <= '0;

          unique case (1'b1)
            d_win: begin
              owner <= OWN_D;
              we_q  <= bus.d_we_i;
              if (d_io) begin
                state     <= DONE;
                d_rdata_q <= '0;
                d_ready_q <= 1'b1;
              end else begin
                state       <= ACCESS;
                ram_ce_q    <= 1'b1;
                ram_we_q    <= bus.d_we_i;
                ram_sel_q   <= bus.d_sel_i;
                ram_addr_q  <= bus.d_addr_i[RAM_AW+1:2];
                ram_wdata_q <= bus.d_wdata_i;
              end
            end
            f_win: begin
              owner       <= OWN_IF;
              we_q        <= 1'b0;
              state       <= ACCESS;
              ram_ce_q    <= 1'b1;
              ram_we_q    <= 1'b0;
              ram_sel_q   <= 4'b1111;
              ram_addr_q  <= bus.if_addr_i[RAM_AW+1:2];
              ram_wdata_q <= '0;
            end
            default: ;
          endcase
        end

        ACCESS: begin
          ram_ce_q    <= 1'b0;
          ram_we_q    <= 1'b0;
          ram_sel_q   <= '0;
          ram_addr_q  <= '0;
          ram_wdata_q <= '0;
          if (we_q) begin
            state      <= DONE;
            d_ready_q  <= (owner == OWN_D);
            if_ready_q <= (owner == OWN_IF);
          end else begin
            state <= READ_CAP;
          end
        end

        READ_CAP: begin
          state <= DONE;
          if (owner == OWN_D) begin
            d_rdata_q <= bus.ram_rdata_i;
            d_ready_q <= 1'b1;
          end else begin
            if_data_q  <= bus.ram_rdata_i;
            if_ready_q <= 1'b1;
          end
        end

        DONE: begin
          state      <= IDLE;
          owner      <= OWN_NONE;
          d_ready_q  <= 1'b0;
          if_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_ce_o    = ram_ce_q;
  assign bus.ram_we_o    = ram_we_q;
  assign bus.ram_sel_o   = ram_sel_q;
  assign bus.ram_addr_o  = ram_addr_q;
  assign bus.ram_wdata_o = ram_wdata_q;
  assign bus.if_data_o   = if_data_q;
  assign bus.if_ready_o  = if_ready_q;
  assign bus.d_rdata_o   = d_rdata_q;
  assign bus.d_ready_o   = d_ready_q;

  assign bus.stall_req_o = (bus.d_ce_i & ~d_ready_q)
                         | (bus.if_ce_i & ~if_ready_q);

endmodule

// File: tb/tb_risc32_mem_arbiter.sv
// Scoreboard bench for risc32_mem_arbiter with a RAM model,
// directed scenarios and randomized concurrent requesters.
module tb_risc32_mem_arbiter;

  localparam int          RAM_AW  = 14;
  localparam logic [31:0] IO_BASE = 32'h0000_F000;
  localparam int          DBM     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  risc32_mem_arbiter_if #(.RAM_AW(RAM_AW)) bus ();

  risc32_mem_arbiter #(
    .RAM_AW(RAM_AW),
    .IO_BASE(IO_BASE),
    .DATA_BURST_MAX(DBM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int dwait = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    bit          chk;
    int          issue;
    int          lat;
  } exp_t;

  typedef struct {
    int                c;
    logic [RAM_AW-1:0] a;
    logic              we;
    logic [3:0]        sel;
    logic [31:0]       wd;
  } acc_t;

  exp_t fq[$];
  exp_t dq[$];
  acc_t rlog[$];
  byte  olog[$];

  logic [31:0] mem [0:(1<<RAM_AW)-1];
  logic [31:0] shadow [int];

  function automatic logic [31:0] init_val(int w);
    logic [31:0] x;
    x = w;
    return (x * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] model_rd(int w);
    if (shadow.exists(w)) return shadow[w];
    return init_val(w);
  endfunction

  function automatic void model_wr(int w, logic [3:0] sel, logic [31:0] d);
    logic [31:0] v;
    v = model_rd(w);
    for (int b = 0; b < 4; b++)
      if (sel[b]) v[8*b +: 8] = d[8*b +: 8];
    shadow[w] = v;
  endfunction

  // synchronous single-port RAM; read data is junk unless just read
  always @(posedge clk) begin
    if (bus.ram_ce_o) begin
      if (bus.ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_sel_o[b])
            mem[bus.ram_addr_o][8*b +: 8] = bus.ram_wdata_o[8*b +: 8];
      end else begin
        bus.ram_rdata_i <= mem[bus.ram_addr_o];
      end
    end else begin
      bus.ram_rdata_i <= $urandom;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic chk_zero(string tag);
    check({tag, "_if_data"}, bus.if_data_o, 0);
    check({tag, "_if_rdy"}, 32'(bus.if_ready_o), 0);
    check({tag, "_d_rdata"}, bus.d_rdata_o, 0);
    check({tag, "_d_rdy"}, 32'(bus.d_ready_o), 0);
    check({tag, "_ram_ce"}, 32'(bus.ram_ce_o), 0);
    check({tag, "_ram_we"}, 32'(bus.ram_we_o), 0);
    check({tag, "_ram_sel"}, 32'(bus.ram_sel_o), 0);
    check({tag, "_ram_addr"}, 32'(bus.ram_addr_o), 0);
    check({tag, "_ram_wd"}, bus.ram_wdata_o, 0);
  endtask

  // monitor: pops the scoreboard whenever a ready pulse is seen
  always @(negedge clk) begin
    exp_t e;
    acc_t r;
    if (rst_n) begin
      if (bus.ram_ce_o) begin
        r.c = cyc;
        r.a = bus.ram_addr_o;
        r.we = bus.ram_we_o;
        r.sel = bus.ram_sel_o;
        r.wd = bus.ram_wdata_o;
        rlog.push_back(r);
      end
      check("stall", 32'(bus.stall_req_o),
            32'((bus.d_ce_i & ~bus.d_ready_o) |
                (bus.if_ce_i & ~bus.if_ready_o)));
      check("ready_overlap", 32'(bus.if_ready_o & bus.d_ready_o), 0);
      if (bus.if_ready_o) begin
        olog.push_back("F");
        if (fq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL if_unexpected: got ready want none");
        end else begin
          e = fq.pop_front();
          if (e.chk) check("if_data", bus.if_data_o, e.data);
          if (e.lat != 0) check("if_lat", 32'(cyc - e.issue), 32'(e.lat));
        end
        check("fairness", 32'(dwait > DBM + 1), 0);
        dwait = 0;
      end
      if (bus.d_ready_o) begin
        olog.push_back("D");
        if (bus.if_ce_i) dwait++;
        if (dq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL d_unexpected: got ready want none");
        end else begin
          e = dq.pop_front();
          if (e.chk) check("d_rdata", bus.d_rdata_o, e.data);
          if (e.lat != 0) check("d_lat", 32'(cyc - e.issue), 32'(e.lat));
        end
      end
    end
  end

  task automatic issue_f(logic [31:0] a, int lat);
    exp_t e;
    @(posedge clk);
    #1;
    bus.if_ce_i = 1'b1;
    bus.if_addr_i = a;
    e.data = model_rd(int'(a[RAM_AW+1:2]));
    e.chk = 1'b1;
    e.issue = cyc;
    e.lat = lat;
    fq.push_back(e);
  endtask

  task automatic issue_d(logic we, logic [3:0] sel, logic [31:0] a,
                         logic [31:0] wd, int lat);
    exp_t e;
    int w;
    @(posedge clk);
    #1;
    bus.d_ce_i = 1'b1;
    bus.d_we_i = we;
    bus.d_sel_i = sel;
    bus.d_addr_i = a;
    bus.d_wdata_i = wd;
    w = int'(a[RAM_AW+1:2]);
    e.issue = cyc;
    e.lat = lat;
    e.data = '0;
    e.chk = !we;
    if (a < IO_BASE) begin
      if (we) model_wr(w, sel, wd);
      else e.data = model_rd(w);
    end
    dq.push_back(e);
  endtask

  task automatic wait_f();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.if_ready_o && n < 200);
    if (!bus.if_ready_o) begin
      tests++;
      fails++;
      $display("FAIL if_timeout: got no ready want ready");
    end
  endtask

  task automatic wait_d();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.d_ready_o && n < 200);
    if (!bus.d_ready_o) begin
      tests++;
      fails++;
      $display("FAIL d_timeout: got no ready want ready");
    end
  endtask

  task automatic drop_f();
    @(posedge clk);
    #1;
    bus.if_ce_i = 1'b0;
  endtask

  task automatic drop_d();
    @(posedge clk);
    #1;
    bus.d_ce_i = 1'b0;
  endtask

  task automatic fetch_agent(int n, int maxgap);
    int g;
    for (int k = 0; k < n; k++) begin
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      if (g > 0) begin
        @(posedge clk);
        #1;
        bus.if_ce_i = 1'b0;
        repeat (g) @(posedge clk);
      end
      issue_f({22'd0, 8'($urandom), 2'b00}, 0);
      wait_f();
    end
    drop_f();
  endtask

  task automatic data_agent(int n, int maxgap);
    int g;
    logic [31:0] a;
    logic [3:0] sel;
    for (int k = 0; k < n; k++) begin
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      if (g > 0) begin
        @(posedge clk);
        #1;
        bus.d_ce_i = 1'b0;
        repeat (g) @(posedge clk);
      end
      if ($urandom_range(7, 0) == 0)
        a = IO_BASE + ($urandom & 32'h0000_0FFF);
      else
        a = (32'($urandom_range(1023, 256)) << 2) | ($urandom & 32'h3);
      sel = 4'($urandom_range(15, 1));
      issue_d(1'($urandom), sel, a, $urandom, 0);
      wait_d();
    end
    drop_d();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

  initial begin
    int s;
    int pd;
    int pf;
    int streak;
    byte exp_o[$];

    for (int i = 0; i < (1 << RAM_AW); i++) mem[i] = init_val(i);
    mem[5] = 32'hDEAD_BEEF;
    shadow[5] = 32'hDEAD_BEEF;

    bus.if_ce_i = 1'b0;
    bus.if_addr_i = '0;
    bus.d_ce_i = 1'b0;
    bus.d_we_i = 1'b0;
    bus.d_sel_i = '0;
    bus.d_addr_i = '0;
    bus.d_wdata_i = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    check("rst_stall", 32'(bus.stall_req_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // fetch read of word 5
    rlog.delete();
    issue_f(32'h14, 3);
    s = cyc;
    wait_f();
    drop_f();
    check("f_acc_n", 32'(rlog.size()), 1);
    if (rlog.size() == 1) begin
      check("f_acc_addr", 32'(rlog[0].a), 5);
      check("f_acc_we", 32'(rlog[0].we), 0);
      check("f_acc_sel", 32'(rlog[0].sel), 32'hF);
      check("f_acc_cyc", 32'(rlog[0].c), 32'(s + 1));
    end

    // data byte write
    rlog.delete();
    issue_d(1'b1, 4'b0100, 32'h21, 32'h5A5A_5A5A, 2);
    s = cyc;
    wait_d();
    drop_d();
    check("w_acc_n", 32'(rlog.size()), 1);
    if (rlog.size() == 1) begin
      check("w_acc_addr", 32'(rlog[0].a), 8);
      check("w_acc_we", 32'(rlog[0].we), 1);
      check("w_acc_sel", 32'(rlog[0].sel), 32'h4);
      check("w_acc_wd", rlog[0].wd, 32'h5A5A_5A5A);
      check("w_acc_cyc", 32'(rlog[0].c), 32'(s + 1));
    end

    // read back merged word
    issue_d(1'b0, 4'hF, 32'h20, 32'h0, 3);
    wait_d();
    drop_d();

    // reset during READ_CAP of a fetch
    @(posedge clk);
    #1;
    bus.if_ce_i = 1'b1;
    bus.if_addr_i = 32'h30;
    s = cyc;
    do @(negedge clk); while (cyc < s + 2);
    check("rc_ram_ce", 32'(bus.ram_ce_o), 0);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    dwait = 0;
    repeat (2) begin
      @(negedge clk);
      check("rst_no_rdy", 32'(bus.if_ready_o), 0);
    end
    begin
      exp_t e;
      e.data = model_rd(12);
      e.chk = 1'b1;
      e.issue = cyc;
      e.lat = 3;
      fq.push_back(e);
    end
    rst_n = 1'b1;
    wait_f();
    drop_f();

    // data read withdrawn during ACCESS
    rlog.delete();
    issue_d(1'b0, 4'hF, 32'h40, 32'h0, 3);
    @(posedge clk);
    #1;
    bus.d_ce_i = 1'b0;
    wait_d();
    repeat (6) @(negedge clk);
    check("wd_acc_n", 32'(rlog.size()), 1);

    // IO-range read
    rlog.delete();
    issue_d(1'b0, 4'hF, 32'h0000_F004, 32'h0, 1);
    wait_d();
    drop_d();
    repeat (2) @(negedge clk);
    check("io_acc_n", 32'(rlog.size()), 0);

    // both requesters held continuously
    olog.delete();
    fork
      fetch_agent(5, 0);
      data_agent(8, 0);
    join
    pd = 8;
    pf = 5;
    streak = 0;
    while (pd > 0 || pf > 0) begin
      if (pd > 0 && !(pf > 0 && streak == DBM)) begin
        exp_o.push_back("D");
        streak = (pf > 0) ? streak + 1 : 0;
        pd--;
      end else begin
        exp_o.push_back("F");
        streak = 0;
        pf--;
      end
    end
    check("order_n", 32'(olog.size()), 32'(exp_o.size()));
    for (int i = 0; i < exp_o.size() && i < olog.size(); i++)
      check($sformatf("order%0d", i), 32'(olog[i]), 32'(exp_o[i]));

    // randomized concurrent traffic
    fork
      fetch_agent(60, 4);
      data_agent(80, 4);
    join
    repeat (5) @(negedge clk);
    check("fq_left", 32'(fq.size()), 0);
    check("dq_left", 32'(dq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/risc32_mem_arbiter.md
Name: risc32_mem_arbiter

Overview:
Shares one single-port synchronous data/instruction RAM between the instruction-fetch requester and the MEM-stage data requester. Latches each request, sequences the RAM access, returns read data and a one-cycle ready pulse, and raises a stall request to the pipeline controller while either requester waits. Data has fixed priority, with a fairness counter that prevents fetch starvation. Data requests at or above the IO boundary are completed without touching RAM.

Parameters:
RAM_AW, 14, RAM word-address width; RAM word address = byte address [RAM_AW+1:2]
IO_BASE, 32'h0000_F000, first byte address not backed by RAM
DATA_BURST_MAX, 4, consecutive data grants allowed while fetch is pending before fetch is forced in (range 1..15)

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
if_ce_i  in  1  fetch request; held until if_ready_o
if_addr_i  in  32  fetch byte address, word aligned
if_data_o  out  32  fetch read data; valid while if_ready_o=1, held afterwards
if_ready_o  out  1  one-cycle fetch completion pulse
d_ce_i  in  1  data request; held until d_ready_o
d_we_i  in  1  1 = write, 0 = read
d_sel_i  in  4  byte lane enables, bit 3 = bits [31:24]
d_addr_i  in  32  data byte address
d_wdata_i  in  32  write data
d_rdata_o  out  32  data read word (raw, unaligned); valid while d_ready_o=1, held afterwards
d_ready_o  out  1  one-cycle data completion pulse
ram_ce_o  out  1  RAM enable
ram_we_o  out  1  RAM write enable
ram_sel_o  out  4  RAM byte enables
ram_addr_o  out  RAM_AW  RAM word address
ram_wdata_o  out  32  RAM write data
ram_rdata_i  in  32  RAM read data; valid in the cycle after an enabled read
stall_req_o  out  1  (d_ce_i & ~d_ready_o) | (if_ce_i & ~if_ready_o); combinational

Behaviour:
- Reset (async, rst_n=0): state IDLE; every registered output = 0, including if_data_o, d_rdata_o and all ram_* outputs. burst_cnt = 0; owner = none. Reset asserted mid-transaction aborts it with no ready pulse; the RAM sees ram_ce_o=0 immediately.
- States: IDLE, ACCESS, READ_CAP, DONE.
- IDLE: if any request, grant, latch owner, addr, we, sel and wdata, then go to ACCESS. Fetch is always read with sel 4'b1111.
  - Grant rule: data wins if d_ce_i & ~(if_ce_i & burst_cnt==DATA_BURST_MAX); otherwise fetch wins if if_ce_i.
  - burst_cnt: +1 on a data grant while if_ce_i=1 (saturating); cleared on a fetch grant, or when IDLE sees if_ce_i=0.
- Out-of-range data (latched addr >= IO_BASE): IDLE goes to DONE directly. ram_ce_o stays 0; d_rdata_o = 0; d_ready_o pulses.
- ACCESS: ram_* outputs are registered from the latched fields with ram_ce_o=1 for exactly this cycle. Next state is READ_CAP for a read, DONE for a write.
- READ_CAP: ram_ce_o=0. At the edge leaving this state, ram_rdata_i is registered into the owner's data output; go to DONE.
- DONE: the owner's ready is 1 for this single cycle; the other requester's ready stays 0. Requests are not sampled. Next state is IDLE.
- Latency from the edge where IDLE samples the request to the start of the ready cycle:
  - read: 3 cycles
  - write: 2 cycles
  - out-of-range data: 1 cycle
- Minimum gap between ready pulses: one IDLE cycle.
- Request dropped after grant: the transaction completes anyway, and ready still pulses.
- The non-owner data output is never modified.
- Simultaneous requests at IDLE follow the grant rule. The loser stays pending, and stall_req_o stays 1 until that loser's ready pulses.

Test Plan:
- Fetch read: RAM word 5 = 32'hDEAD_BEEF, if_ce_i=1, if_addr_i=32'h14 -> ram_addr_o=5 with ram_ce_o=1 for one cycle; if_data_o=32'hDEAD_BEEF with if_ready_o=1 exactly 3 cycles after sampling; stall_req_o=1 until then.
- Data byte write: d_we_i=1, d_sel_i=4'b0100, d_addr_i=32'h21, d_wdata_i=32'h5A5A_5A5A -> ram_addr_o=8, ram_sel_o=4'b0100, ram_we_o=1 for one cycle; d_ready_o 2 cycles after sampling; if_ready_o stays 0.
- Contention: both held continuously, DATA_BURST_MAX=4 -> grant order D,D,D,D,F,D,D,D,D,F; each ready pulse goes only to its owner.
- IO address: d_ce_i=1, d_we_i=0, d_addr_i=32'h0000_F004 -> ram_ce_o never 1; d_rdata_o=0 and d_ready_o=1 one cycle after sampling.
- Reset mid-read: rst_n low during READ_CAP -> all outputs 0 immediately, no ready pulse; after release, a held request is re-granted from IDLE.
- Request withdrawn: d_ce_i dropped in ACCESS -> the read still completes; d_ready_o pulses once; no further grant.
